// File: rtl/riscv_pkg.sv
// Shared core package: widths, reset PC, opcode
// constants and the fetch buffer entry type.
package riscv_pkg;

  localparam int PC_W = 32;
  localparam int INST_W = 32;
  localparam logic [PC_W-1:0] RESET_PC = '0;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, inst}
// entries with flush; head is read combinationally.
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push & ~flush;
  assign do_pop  = pop & ~flush;
  assign head    = mem[rd_ptr];

  // Entry storage; no reset needed, occupancy gates use.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; flush empties the buffer.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-based issue
// to a 1-cycle imem, and a buffer toward decode.
module fetch_unit #(
  parameter int PC_W = 32,
  parameter int INST_W = 32,
  parameter int DEPTH = 2,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   inst_pc,
  output logic [6:0]        inst_opcode
);

  import riscv_pkg::*;

  localparam int CW = $clog2(DEPTH) + 1;

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pend_pc_q;
  logic            pend_q;
  logic [CW-1:0]   cnt;
  logic [CW:0]     credit;
  logic            pop;
  logic            push;
  fetch_entry_t    push_entry;
  fetch_entry_t    head;

  assign pop    = inst_valid & inst_ready;
  assign push   = pend_q & ~redirect_valid;
  assign credit = {1'b0, cnt}
                + {{CW{1'b0}}, pend_q}
                - {{CW{1'b0}}, pop};

  assign imem_req  = !reset && !redirect_valid
                   && (credit < (CW+1)'(DEPTH));
  assign imem_addr = imem_req ? pc_q : '0;

  assign push_entry.pc   = pend_pc_q;
  assign push_entry.inst = imem_rdata;

  assign inst_valid  = (cnt != '0);
  assign inst        = inst_valid ? head.inst : '0;
  assign inst_pc     = inst_valid ? head.pc : '0;
  assign inst_opcode = inst[6:0];

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (cnt)
  );

  // PC advance and outstanding-fetch tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
    end else if (redirect_valid) begin
      pc_q   <= {redirect_pc[PC_W-1:2], 2'b00};
      pend_q <= 1'b0;
    end else if (imem_req) begin
      pc_q      <= pc_q + PC_W'(4);
      pend_q    <= 1'b1;
      pend_pc_q <= pc_q;
    end else begin
      pend_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and scoreboard bench for fetch_unit
// with a 1-cycle synchronous instruction memory.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic [6:0]  inst_opcode;

  int checks = 0;
  int errors = 0;

  fetch_unit #(
    .PC_W(32), .INST_W(32), .DEPTH(2), .RESET_PC(32'h0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .inst_valid    (inst_valid),
    .inst_ready    (inst_ready),
    .inst          (inst),
    .inst_pc       (inst_pc),
    .inst_opcode   (inst_opcode)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[24:0], 7'b0110011};
  endfunction

  always @(posedge clk) begin
    imem_rdata <= imem_req ? word(imem_addr) : 32'hDEAD_BEEF;
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic rdy,
                     input logic rv, input logic [31:0] rpc);
    @(posedge clk);
    #1;
    reset          = r;
    inst_ready     = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #1;
  endtask

  logic [31:0] exp_pc;
  logic        rdy_r;
  logic        rv_r;
  int          pops;

  initial begin
    reset          = 1'b1;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_rdata     = '0;
    pops           = 0;

    // reset state
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_inst", inst, 0);
    chk("rst_pc", inst_pc, 0);
    chk("rst_op", inst_opcode, 0);

    // sequential streaming
    cyc(0, 1, 0, 0);
    chk("s0_req", imem_req, 1);
    chk("s0_addr", imem_addr, 32'h0);
    chk("s0_valid", inst_valid, 0);
    cyc(0, 1, 0, 0);
    chk("s1_addr", imem_addr, 32'h4);
    chk("s1_valid", inst_valid, 0);
    cyc(0, 1, 0, 0);
    chk("s2_addr", imem_addr, 32'h8);
    chk("s2_valid", inst_valid, 1);
    chk("s2_pc", inst_pc, 32'h0);
    chk("s2_inst", inst, 32'h33);
    chk("s2_op", inst_opcode, 7'b0110011);
    cyc(0, 1, 0, 0);
    chk("s3_pc", inst_pc, 32'h4);
    chk("s3_inst", inst, 32'h233);
    chk("s3_addr", imem_addr, 32'hC);
    cyc(0, 1, 0, 0);
    chk("s4_pc", inst_pc, 32'h8);

    // mid-stream reset, then backpressure
    cyc(1, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("r_valid", inst_valid, 0);
    chk("r_pc", inst_pc, 0);
    cyc(0, 0, 0, 0);
    chk("b0_addr", imem_addr, 32'h0);
    chk("b0_req", imem_req, 1);
    cyc(0, 0, 0, 0);
    chk("b1_addr", imem_addr, 32'h4);
    cyc(0, 0, 0, 0);
    chk("b2_req", imem_req, 0);
    chk("b2_pc", inst_pc, 32'h0);
    cyc(0, 0, 0, 0);
    chk("b3_req", imem_req, 0);
    chk("b3_valid", inst_valid, 1);
    cyc(0, 1, 0, 0);
    chk("b4_pc", inst_pc, 32'h0);
    chk("b4_addr", imem_addr, 32'h8);
    cyc(0, 1, 0, 0);
    chk("b5_pc", inst_pc, 32'h4);
    chk("b5_addr", imem_addr, 32'hC);
    cyc(0, 1, 0, 0);
    chk("b6_pc", inst_pc, 32'h8);
    cyc(0, 1, 0, 0);
    chk("b7_pc", inst_pc, 32'hC);

    // redirect with pending response and valid head
    cyc(0, 1, 1, 32'h103);
    chk("rd_valid", inst_valid, 1);
    chk("rd_req", imem_req, 0);
    cyc(0, 1, 0, 0);
    chk("rd1_addr", imem_addr, 32'h100);
    chk("rd1_valid", inst_valid, 0);
    cyc(0, 1, 0, 0);
    chk("rd2_addr", imem_addr, 32'h104);
    chk("rd2_valid", inst_valid, 0);
    cyc(0, 1, 0, 0);
    chk("rd3_pc", inst_pc, 32'h100);
    chk("rd3_inst", inst, 32'h8033);
    cyc(0, 1, 0, 0);
    chk("rd4_pc", inst_pc, 32'h104);

    // PC wrap
    cyc(0, 1, 1, 32'hFFFF_FFFC);
    chk("w_req", imem_req, 0);
    cyc(0, 1, 0, 0);
    chk("w1_addr", imem_addr, 32'hFFFF_FFFC);
    cyc(0, 1, 0, 0);
    chk("w2_addr", imem_addr, 32'h0);
    cyc(0, 1, 0, 0);
    chk("w3_pc", inst_pc, 32'hFFFF_FFFC);
    chk("w3_inst", inst, 32'hFFFF_FE33);
    cyc(0, 1, 0, 0);
    chk("w4_pc", inst_pc, 32'h0);

    // reset with a full buffer
    cyc(0, 0, 0, 0);
    chk("f_req", imem_req, 0);
    cyc(1, 0, 0, 0);
    chk("f_rst_req", imem_req, 0);
    cyc(1, 0, 0, 0);
    chk("f_valid", inst_valid, 0);
    chk("f_inst", inst, 0);
    chk("f_addr", imem_addr, 0);
    cyc(0, 1, 0, 0);
    chk("f0_addr", imem_addr, 32'h0);
    cyc(0, 1, 0, 0);
    chk("f1_valid", inst_valid, 0);
    cyc(0, 1, 0, 0);
    chk("f2_pc", inst_pc, 32'h0);
    chk("f2_inst", inst, 32'h33);

    // random backpressure and redirects vs scoreboard
    exp_pc = '0;
    for (int i = 0; i < 1000; i++) begin
      rdy_r = ($urandom % 10) < 7;
      rv_r  = (i == 0) || (($urandom % 40) == 0);
      cyc(0, rdy_r, rv_r, (i == 0) ? 32'h2001 : $urandom);
      if (rv_r) begin
        exp_pc = {redirect_pc[31:2], 2'b00};
      end else if (inst_valid && rdy_r) begin
        chk("sb_pc", inst_pc, exp_pc);
        chk("sb_inst", inst, word(exp_pc));
        exp_pc = exp_pc + 32'd4;
        pops++;
      end
    end
    chk("sb_pops", pops > 200, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
